multi_signal_formatter: RTL and testbench
=========================================

# multi_signal_formatter

Multi-channel, parametrised successor to the single-line trigger formatter. Each channel synchronises and debounces an external line and regenerates it cleanly. It flags rising and falling edges, and issues a one-cycle start pulse on a per-channel selectable edge, followed by a runtime-programmable veto window. Edges suppressed by the veto are counted for diagnostics. Sits between the board trigger/sync inputs and the acquisition start logic.

## Interface
- N_CH, 4, number of independent channels
- DIV_WIDTH, 5, prescaler counter width
- DIV, 10, sample-tick period in clk cycles (1..2^DIV_WIDTH-1); 200 MHz -> 20 MHz
- STABLE, 2, consecutive ticks a new level must persist before acceptance (1..15)
- VETO_WIDTH, 17, veto counter width
- CNT_WIDTH, 16, suppressed-edge counter width per channel

- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset (0 = reset)
- sig_in  in  N_CH  raw asynchronous lines
- ch_enable  in  N_CH  per-channel start enable
- edge_mode  in  2*N_CH  per channel: 00 falling, 01 rising, 10 both, 11 none
- veto_len  in  VETO_WIDTH  veto length; latched when each veto starts
- clear_cnt  in  1  synchronous clear of all suppressed-edge counters
- sig_out  out  N_CH  debounced line; reset 1
- rise, fall  out  N_CH each  one-cycle accepted-edge pulses; reset 0
- start_pulse  out  N_CH  one-cycle start pulse; reset 0
- busy  out  N_CH  high while the channel is in VETO; reset 0
- sup_cnt  out  N_CH*CNT_WIDTH  saturating count of qualifying edges suppressed; reset 0; channel k occupies bits [k*CNT_WIDTH +: CNT_WIDTH]

## Operation
- Shared prescaler: counts 0..DIV-1 and asserts tick when the count is DIV-1. With DIV=1, tick is asserted every cycle.
- Per channel, in this order:
  - 2-FF synchroniser.
  - Debounce: on each tick, if the synchronised level differs from sig_out, the stability counter increments; otherwise it clears. When the counter reaches STABLE, sig_out toggles, the matching rise or fall pulse fires, and the counter clears.
- A qualifying edge is an accepted edge that matches edge_mode.
- Channel FSM states: RESET -> IDLE unconditionally, one cycle after rst deasserts.
  - IDLE: a qualifying edge with ch_enable=1 drives start_pulse high in the same cycle, clears the veto counter, latches veto_len, and moves to VETO.
  - VETO: the counter increments every cycle. When counter == latched length, the next state is IDLE. VETO therefore lasts veto_len+1 cycles; veto_len=0 gives one cycle.
- A qualifying edge while in VETO increments sup_cnt, saturating at all-ones. clear_cnt has priority over an increment in the same cycle.
- edge_mode changes take effect immediately and do not abort a veto in progress.
- ch_enable=0 forces IDLE and clears the veto counter. sig_out, rise, fall and sup_cnt keep operating.
- Reset mid-operation: all outputs and state return to their reset values immediately, asynchronously.

## Timing
- rise and fall coincide with the cycle in which sig_out changes (registered).
- start_pulse is combinational from fall/rise, state and enable. It coincides with the accepted edge.
- Latency from a sig_in change to the accepted edge is between 3+DIV*(STABLE-1) and 3+DIV*STABLE cycles.
- Minimum pulse width guaranteed to be accepted: DIV*(STABLE+1) cycles. Pulses shorter than DIV*(STABLE-1) cycles are always rejected.
- An edge in the first IDLE cycle after VETO qualifies.
- With DIV>=2, rise and fall cannot both fire in the same cycle on one channel.
- If the line is low at reset release, a fall is accepted after the debounce latency. start_pulse then fires if the channel is enabled and in IDLE.

## Structure
- Package msf_pkg holds:
  - edge_mode encodings (EM_FALL, EM_RISE, EM_BOTH, EM_NONE)
  - FSM state constants (RESET, IDLE, VETO)
- Sub-module msf_channel: synchroniser, debounce, FSM, veto counter and sup_cnt for one channel. It takes the shared tick as an input.
- The top level holds only the prescaler and a generate loop over N_CH channels.

## Test plan
- DIV=10, STABLE=2, ch0 falling mode: hold sig_in[0] low for 100 cycles -> fall[0] and start_pulse[0] fire once, 13..23 cycles after the drop; sig_out[0]=0 and busy[0]=1.
- 5-cycle low glitch on ch1 -> no fall, no start_pulse, sig_out[1] stays 1.
- veto_len=50, two falls 30 cycles apart on ch0 -> one start_pulse, sup_cnt[0]=1; busy high for exactly 51 cycles. A third fall after busy drops -> second start_pulse.
- ch2 in mode 10 (both): square wave with 200-cycle period, veto_len=0 -> start_pulse on every rise and every fall. ch3 in mode 11 -> no start_pulses.
- Force sup_cnt to saturate (CNT_WIDTH=4, 20 suppressed edges) -> holds at 15. Assert clear_cnt in the same cycle as a suppressed edge -> reads 0.
- Assert rst mid-VETO -> busy=0, sig_out=1, all counters 0 immediately; one cycle after release the FSM is in IDLE.

Source files
------------

// File: rtl/msf_pkg.sv
// multi_signal_formatter shared types
// edge-mode and channel-state encodings plus the edge qualifier
package msf_pkg;

  typedef enum logic [1:0] {
    EM_FALL = 2'b00,
    EM_RISE = 2'b01,
    EM_BOTH = 2'b10,
    EM_NONE = 2'b11
  } edge_mode_e;

  typedef enum logic [1:0] {
    RESET = 2'b00,
    IDLE  = 2'b01,
    VETO  = 2'b10
  } state_e;

  function automatic logic edge_qual(
    input logic [1:0] mode,
    input logic       r,
    input logic       f
  );
    logic q;
    q = 1'b0;
    unique case (1'b1)
      mode == EM_FALL: q = f;
      mode == EM_RISE: q = r;
      mode == EM_BOTH: q = r | f;
      mode == EM_NONE: q = 1'b0;
    endcase
    return q;
  endfunction

endpackage

// File: rtl/multi_signal_formatter_if.sv
// multi_signal_formatter bus
// raw lines and controls in, conditioned lines and diagnostics out
interface multi_signal_formatter_if #(
  parameter int N_CH       = 4,
  parameter int VETO_WIDTH = 17,
  parameter int CNT_WIDTH  = 16
);
  logic [N_CH-1:0]           sig_in;
  logic [N_CH-1:0]           ch_enable;
  logic [2*N_CH-1:0]         edge_mode;
  logic [VETO_WIDTH-1:0]     veto_len;
  logic                      clear_cnt;
  logic [N_CH-1:0]           sig_out;
  logic [N_CH-1:0]           rise;
  logic [N_CH-1:0]           fall;
  logic [N_CH-1:0]           start_pulse;
  logic [N_CH-1:0]           busy;
  logic [N_CH*CNT_WIDTH-1:0] sup_cnt;

  modport master (
    output sig_in, ch_enable, edge_mode,
    output veto_len, clear_cnt,
    input  sig_out, rise, fall,
    input  start_pulse, busy, sup_cnt
  );

  modport slave (
    input  sig_in, ch_enable, edge_mode,
    input  veto_len, clear_cnt,
    output sig_out, rise, fall,
    output start_pulse, busy, sup_cnt
  );
endinterface

// File: rtl/msf_channel.sv
// one formatter channel
// sync, debounce, start/veto FSM and suppressed-edge counter
module msf_channel
  import msf_pkg::*;
#(
  parameter int STABLE     = 2,
  parameter int VETO_WIDTH = 17,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick,
  input  logic                  sig_in,
  input  logic                  ch_enable,
  input  logic [1:0]            edge_mode,
  input  logic [VETO_WIDTH-1:0] veto_len,
  input  logic                  clear_cnt,
  output logic                  sig_out,
  output logic                  rise,
  output logic                  fall,
  output logic                  start_pulse,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  sup_cnt
);

  logic s1_q, s1_d, s2_q, s2_d;
  logic out_q, out_d;
  logic rise_q, rise_d, fall_q, fall_d;
  logic [3:0] stab_q, stab_d;
  state_e state_q, state_d;
  logic [VETO_WIDTH-1:0] cnt_q, cnt_d;
  logic [VETO_WIDTH-1:0] len_q, len_d;
  logic [CNT_WIDTH-1:0] sup_q, sup_d;
  logic qual;

  assign qual = edge_qual(edge_mode, rise_q, fall_q);

  always_comb begin
    s1_d   = sig_in;
    s2_d   = s1_q;
    out_d  = out_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    stab_d = stab_q;
    if (tick) begin
      if (s2_q != out_q) begin
        stab_d = stab_q + 4'd1;
        if (stab_d == 4'(STABLE)) begin
          out_d  = s2_q;
          rise_d = s2_q;
          fall_d = ~s2_q;
          stab_d = '0;
        end
      end else begin
        stab_d = '0;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    start_pulse = 1'b0;
    unique case (state_q)
      RESET: state_d = IDLE;
      IDLE: begin
        if (ch_enable && qual) begin
          start_pulse = 1'b1;
          cnt_d       = '0;
          len_d       = veto_len;
          state_d     = VETO;
        end
      end
      VETO: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == len_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (!ch_enable) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  // clear wins over a coincident suppressed edge
  always_comb begin
    sup_d = sup_q;
    if (clear_cnt) begin
      sup_d = '0;
    end else if (state_q == VETO && qual && !(&sup_q)) begin
      sup_d = sup_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q    <= 1'b1;
      s2_q    <= 1'b1;
      out_q   <= 1'b1;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      stab_q  <= '0;
      state_q <= RESET;
      cnt_q   <= '0;
      len_q   <= '0;
      sup_q   <= '0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      out_q   <= out_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      stab_q  <= stab_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      sup_q   <= sup_d;
    end
  end

  assign sig_out = out_q;
  assign rise    = rise_q;
  assign fall    = fall_q;
  assign busy    = (state_q == VETO);
  assign sup_cnt = sup_q;

endmodule

// File: rtl/multi_signal_formatter.sv
// multi-channel trigger formatter top
// shared sample-tick prescaler feeding N_CH independent channels
module multi_signal_formatter #(
  parameter int N_CH       = 4,
  parameter int DIV_WIDTH  = 5,
  parameter int DIV        = 10,
  parameter int STABLE     = 2,
  parameter int VETO_WIDTH = 17,
  parameter int CNT_WIDTH  = 16
) (
  input logic clk,
  input logic rst,
  multi_signal_formatter_if.slave bus
);

  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic tick;

  logic [N_CH-1:0] out_w, rise_w, fall_w;
  logic [N_CH-1:0] start_w, busy_w;
  logic [N_CH*CNT_WIDTH-1:0] sup_w;

  assign tick = (div_q == DIV_WIDTH'(DIV - 1));

  always_comb begin
    div_d = tick ? '0 : div_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) div_q <= '0;
    else      div_q <= div_d;
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    msf_channel #(
      .STABLE    (STABLE),
      .VETO_WIDTH(VETO_WIDTH),
      .CNT_WIDTH (CNT_WIDTH)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .tick       (tick),
      .sig_in     (bus.sig_in[k]),
      .ch_enable  (bus.ch_enable[k]),
      .edge_mode  (bus.edge_mode[2*k +: 2]),
      .veto_len   (bus.veto_len),
      .clear_cnt  (bus.clear_cnt),
      .sig_out    (out_w[k]),
      .rise       (rise_w[k]),
      .fall       (fall_w[k]),
      .start_pulse(start_w[k]),
      .busy       (busy_w[k]),
      .sup_cnt    (sup_w[k*CNT_WIDTH +: CNT_WIDTH])
    );
  end

  assign bus.sig_out     = out_w;
  assign bus.rise        = rise_w;
  assign bus.fall        = fall_w;
  assign bus.start_pulse = start_w;
  assign bus.busy        = busy_w;
  assign bus.sup_cnt     = sup_w;

endmodule

// File: tb/tb_multi_signal_formatter.sv
// bench for multi_signal_formatter
// directed vectors, corner sequences and random traffic vs a reference model
module tb_multi_signal_formatter;

  localparam int N   = 4;
  localparam int DIV = 10;
  localparam int ST  = 2;
  localparam int VW  = 17;
  localparam int CW  = 4;
  localparam int SAT = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;

  multi_signal_formatter_if #(
    .N_CH(N), .VETO_WIDTH(VW), .CNT_WIDTH(CW)
  ) bus ();

  multi_signal_formatter #(
    .N_CH(N), .DIV_WIDTH(5), .DIV(DIV), .STABLE(ST),
    .VETO_WIDTH(VW), .CNT_WIDTH(CW)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ch; int mode; int en; int low;
    int efall; int erise; int estart;
  } vec_t;

  vec_t vecs[8];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc_n = 0;

  // reference model: abstract per-channel state (veto as cycles remaining)
  int m_div;
  int m_s1[N], m_s2[N], m_out[N], m_rise[N], m_fall[N];
  int m_stab[N], m_st[N], m_rem[N], m_sup[N];

  int cnt_fall[N], cnt_rise[N], cnt_start[N], cnt_busy[N];
  int watch = 0;
  int ff_cyc = -1;

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc_n);
    end
  endtask

  function automatic int q(input int mode, input int r, input int f);
    case (mode)
      0: return f;
      1: return r;
      2: return (r != 0 || f != 0) ? 1 : 0;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_div = 0;
    for (int c = 0; c < N; c++) begin
      m_s1[c] = 1; m_s2[c] = 1; m_out[c] = 1;
      m_rise[c] = 0; m_fall[c] = 0; m_stab[c] = 0;
      m_st[c] = 0; m_rem[c] = 0; m_sup[c] = 0;
    end
  endtask

  task automatic model_step();
    int tk, md, en, qq, nr, nf;
    if (!rst) begin
      model_reset();
      return;
    end
    tk = (m_div == DIV - 1);
    m_div = tk ? 0 : m_div + 1;
    for (int c = 0; c < N; c++) begin
      md = int'(bus.edge_mode[2*c +: 2]);
      en = int'(bus.ch_enable[c]);
      qq = q(md, m_rise[c], m_fall[c]);
      if (bus.clear_cnt) m_sup[c] = 0;
      else if (m_st[c] == 2 && qq != 0 && m_sup[c] < SAT) m_sup[c]++;
      if (m_st[c] == 0 || en == 0) begin
        m_st[c] = 1;
      end else if (m_st[c] == 1) begin
        if (qq != 0) begin
          m_st[c] = 2;
          m_rem[c] = int'(bus.veto_len);
        end
      end else if (m_rem[c] == 0) begin
        m_st[c] = 1;
      end else begin
        m_rem[c]--;
      end
      nr = 0; nf = 0;
      if (tk != 0) begin
        if (m_s2[c] != m_out[c]) begin
          m_stab[c]++;
          if (m_stab[c] == ST) begin
            m_out[c] = m_s2[c];
            nr = m_s2[c];
            nf = (m_s2[c] == 0);
            m_stab[c] = 0;
          end
        end else begin
          m_stab[c] = 0;
        end
      end
      m_rise[c] = nr;
      m_fall[c] = nf;
      m_s2[c] = m_s1[c];
      m_s1[c] = int'(bus.sig_in[c]);
    end
  endtask

  task automatic cyc();
    logic [63:0] a, e;
    logic [N-1:0] eo, er, ef, es, eb;
    logic [N*CW-1:0] esup;
    @(negedge clk);
    for (int c = 0; c < N; c++) begin
      eo[c] = (m_out[c] != 0);
      er[c] = (m_rise[c] != 0);
      ef[c] = (m_fall[c] != 0);
      eb[c] = (m_st[c] == 2);
      es[c] = (m_st[c] == 1) && bus.ch_enable[c] &&
              q(int'(bus.edge_mode[2*c +: 2]), m_rise[c], m_fall[c]) != 0;
      esup[c*CW +: CW] = CW'(m_sup[c]);
    end
    a = {28'h0, bus.sig_out, bus.rise, bus.fall,
         bus.start_pulse, bus.busy, bus.sup_cnt};
    e = {28'h0, eo, er, ef, es, eb, esup};
    check("model_outputs", a, e);
    for (int c = 0; c < N; c++) begin
      cnt_fall[c]  += int'(bus.fall[c]);
      cnt_rise[c]  += int'(bus.rise[c]);
      cnt_start[c] += int'(bus.start_pulse[c]);
      cnt_busy[c]  += int'(bus.busy[c]);
    end
    if (bus.fall[watch] === 1'b1 && ff_cyc < 0) ff_cyc = cyc_n;
    @(posedge clk);
    model_step();
    cyc_n++;
    #1;
  endtask

  task automatic clr_counts();
    for (int c = 0; c < N; c++) begin
      cnt_fall[c] = 0; cnt_rise[c] = 0;
      cnt_start[c] = 0; cnt_busy[c] = 0;
    end
    ff_cyc = -1;
  endtask

  task automatic pulse_low(input int c, input int lo, input int hi);
    bus.sig_in[c] = 1'b0;
    repeat (lo) cyc();
    bus.sig_in[c] = 1'b1;
    repeat (hi) cyc();
  endtask

  initial begin
    int drop, lat, found;
    vecs = '{
      '{0, 0, 1, 100, 1, 1, 1},
      '{1, 0, 1,   5, 0, 0, 0},
      '{2, 1, 1, 100, 1, 1, 1},
      '{3, 3, 1, 100, 1, 1, 0},
      '{0, 2, 1, 100, 1, 1, 2},
      '{1, 2, 0, 100, 1, 1, 0},
      '{2, 0, 1,  30, 1, 1, 1},
      '{3, 2, 1,   9, 0, 0, 0}
    };
    bus.sig_in    = '1;
    bus.ch_enable = '1;
    bus.edge_mode = '1;
    bus.veto_len  = 17'd5;
    bus.clear_cnt = 1'b0;
    model_reset();
    clr_counts();
    repeat (3) cyc();
    check("reset_flags",
          {bus.sig_out, bus.rise, bus.fall, bus.start_pulse, bus.busy},
          20'hF0000);
    check("reset_sup", bus.sup_cnt, 0);
    rst = 1'b1;
    repeat (30) cyc();

    for (int v = 0; v < 8; v++) begin
      bus.edge_mode[2*vecs[v].ch +: 2] = 2'(vecs[v].mode);
      bus.ch_enable[vecs[v].ch] = (vecs[v].en != 0);
      watch = vecs[v].ch;
      clr_counts();
      drop = cyc_n;
      pulse_low(vecs[v].ch, vecs[v].low, 80);
      check($sformatf("v%0d_falls", v), cnt_fall[vecs[v].ch], vecs[v].efall);
      check($sformatf("v%0d_rises", v), cnt_rise[vecs[v].ch], vecs[v].erise);
      check($sformatf("v%0d_starts", v), cnt_start[vecs[v].ch], vecs[v].estart);
      check($sformatf("v%0d_sig_out", v), bus.sig_out[vecs[v].ch], 1);
      if (vecs[v].efall > 0) begin
        lat = ff_cyc - drop;
        check($sformatf("v%0d_latency_%0d", v, lat),
              (lat >= 3 + DIV*(ST-1) && lat <= 3 + DIV*ST), 1);
      end
      bus.ch_enable = '1;
    end

    // both-edge mode, zero veto, against a mode-none twin
    bus.edge_mode = 8'b11_10_11_11;
    bus.veto_len = '0;
    clr_counts();
    for (int p = 0; p < 3; p++) begin
      bus.sig_in[2] = 1'b0; bus.sig_in[3] = 1'b0;
      repeat (100) cyc();
      bus.sig_in[2] = 1'b1; bus.sig_in[3] = 1'b1;
      repeat (100) cyc();
    end
    check("sq_both_starts", cnt_start[2], 6);
    check("sq_none_starts", cnt_start[3], 0);
    check("sq_none_falls", cnt_fall[3], 3);

    // veto window suppresses a second fall
    bus.edge_mode = 8'b11_11_11_00;
    bus.veto_len = 17'd80;
    bus.clear_cnt = 1'b1;
    cyc();
    bus.clear_cnt = 1'b0;
    clr_counts();
    pulse_low(0, 30, 30);
    pulse_low(0, 30, 120);
    check("veto_starts", cnt_start[0], 1);
    check("veto_falls", cnt_fall[0], 2);
    check("veto_sup", bus.sup_cnt[0 +: CW], 1);
    check("veto_busy_len", cnt_busy[0], 81);
    pulse_low(0, 40, 60);
    check("post_veto_starts", cnt_start[0], 2);

    // saturate ch1, then clear on a suppressed edge
    bus.edge_mode = 8'b11_11_10_11;
    bus.veto_len = 17'd100000;
    for (int p = 0; p < 11; p++) pulse_low(1, 40, 40);
    check("sat_sup", bus.sup_cnt[CW +: CW], SAT);
    check("sat_busy", bus.busy[1], 1);
    found = 0;
    bus.sig_in[1] = 1'b0;
    for (int i = 0; i < 60 && found == 0; i++) begin
      cyc();
      if (m_fall[1] != 0) begin
        found = 1;
        bus.clear_cnt = 1'b1;
        cyc();
        bus.clear_cnt = 1'b0;
      end
    end
    check("clr_edge_found", found, 1);
    check("clr_beats_inc", bus.sup_cnt[CW +: CW], 0);

    // async reset mid-veto, line held low through release
    bus.edge_mode = 8'b11_11_10_00;
    bus.veto_len = 17'd1000;
    bus.sig_in[0] = 1'b0;
    repeat (40) cyc();
    check("pre_rst_busy", bus.busy[1:0], 2'b11);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check("rst_mid_flags",
          {bus.sig_out, bus.rise, bus.fall, bus.start_pulse, bus.busy},
          20'hF0000);
    check("rst_mid_sup", bus.sup_cnt, 0);
    repeat (3) cyc();
    rst = 1'b1;
    clr_counts();
    watch = 0;
    drop = cyc_n;
    repeat (40) cyc();
    lat = ff_cyc - drop;
    check($sformatf("low_rel_latency_%0d", lat),
          (lat >= 3 + DIV*(ST-1) && lat <= 3 + DIV*ST), 1);
    check("low_rel_start", cnt_start[0], 1);
    bus.sig_in[0] = 1'b1;
    bus.veto_len = 17'd5;
    repeat (100) cyc();

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < N; c++)
        if ($urandom_range(19) == 0) bus.sig_in[c] = ~bus.sig_in[c];
      if ($urandom_range(99) == 0) bus.edge_mode = 8'($urandom);
      if ($urandom_range(149) == 0) bus.ch_enable = 4'($urandom);
      bus.clear_cnt = ($urandom_range(79) == 0);
      bus.veto_len = 17'($urandom_range(40));
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
